// File: rtl/uart_tx_ctrl_if.sv
// Handshake and serial-line bundle between a frame source and uart_tx_ctrl.
// PAR_Bit is supplied by the external parity_generator on the source side.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_Bit;
  logic                  Par_Gen_EN;
  logic [DATA_WIDTH-1:0] Par_Data;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_Bit,
    input  Par_Gen_EN, Par_Data, TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_Bit,
    output Par_Gen_EN, Par_Data, TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART frame sequencer: start bit, LSB-first data, optional parity, stop bit.
// Line outputs are registered from the next-state decode so they align with the state.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_ctrl_if.slave tx_if
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] par_data_q, par_data_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  gen_en_q, gen_en_d;

  // Next-state, latch and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    par_data_d = par_data_q;
    par_en_d   = par_en_q;
    tx_d       = 1'b1;

    case (state_q)
      IDLE: begin
        if (tx_if.Data_Valid) begin
          state_d    = START;
          par_data_d = tx_if.P_DATA;
          par_en_d   = tx_if.PAR_EN;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = CNT_ZERO;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = CNT_ZERO;
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Outputs follow the state being entered, so the flops line up with state_q.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = par_data_d[cnt_d];
      PARITY:  tx_d = tx_if.PAR_Bit;
      default: tx_d = 1'b1;
    endcase

    busy_d   = (state_d != IDLE);
    gen_en_d = (state_d == START);
  end

  // State, latched frame and registered line outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      par_data_q <= {DATA_WIDTH{1'b0}};
      par_en_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      gen_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      par_data_q <= par_data_d;
      par_en_q   <= par_en_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      gen_en_q   <= gen_en_d;
    end
  end

  assign tx_if.TX_OUT     = tx_q;
  assign tx_if.Busy       = busy_q;
  assign tx_if.Par_Gen_EN = gen_en_q;
  assign tx_if.Par_Data   = par_data_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural parity_generator alongside.
module tb_uart_tx_ctrl;
  logic CLK;
  logic RST;
  logic par_typ;  // 0 = even, 1 = odd
  int   n_vec;
  int   n_err;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .tx_if (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered parity generator, enabled by Par_Gen_EN.
  always @(posedge CLK or negedge RST) begin
    if (!RST)                bus.PAR_Bit <= 1'b0;
    else if (bus.Par_Gen_EN) bus.PAR_Bit <= par_typ ? ~^bus.Par_Data : ^bus.Par_Data;
  end

  // bits: first transmitted bit is bit 10, frame left-aligned.
  typedef struct {
    logic [7:0]  data;
    logic        pen;
    logic        ptyp;
    logic [10:0] bits;
    int          len;
    int          mode;  // 0 plain, 1 mid-frame disturbance
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Entered on a negedge with Data_Valid already high; mode 2 keeps it high
  // and loads new_data mid-frame for a back-to-back follow-up.
  task automatic check_frame(input logic [7:0] exp_data, input logic [10:0] exp_bits,
                             input int len, input int mode, input logic [7:0] new_data,
                             input string name);
    @(posedge CLK);
    @(negedge CLK);
    if (mode != 2) bus.Data_Valid = 1'b0;
    chk({name, " par_data"}, 32'(bus.Par_Data), 32'(exp_data));
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s tx[%0d]", name, i), 32'(bus.TX_OUT), 32'(exp_bits[10-i]));
      chk($sformatf("%s busy[%0d]", name, i), 32'(bus.Busy), 32'd1);
      chk($sformatf("%s gen_en[%0d]", name, i), 32'(bus.Par_Gen_EN), (i == 0) ? 32'd1 : 32'd0);
      if (i == 3 && mode == 1) begin
        bus.P_DATA     = ~bus.P_DATA;
        bus.PAR_EN     = ~bus.PAR_EN;
        bus.Data_Valid = 1'b1;
      end
      if (i == 4 && mode == 1) bus.Data_Valid = 1'b0;
      if (i == 3 && mode == 2) bus.P_DATA = new_data;
      @(negedge CLK);
    end
    chk({name, " idle tx"}, 32'(bus.TX_OUT), 32'd1);
    chk({name, " idle busy"}, 32'(bus.Busy), 32'd0);
    chk({name, " idle gen_en"}, 32'(bus.Par_Gen_EN), 32'd0);
  endtask

  task automatic send(input vec_t v, input string name);
    bus.P_DATA     = v.data;
    bus.PAR_EN     = v.pen;
    par_typ        = v.ptyp;
    bus.Data_Valid = 1'b1;
    check_frame(v.data, v.bits, v.len, v.mode, 8'h00, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 11'b0_10100101_0_1, 11, 0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 11'b0_10100101_1_1, 11, 0};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 11'b0_10100101_1_0, 10, 0};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 11'b0_00111100_0_1, 11, 1};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 11'b0_10000000_1_1, 11, 0};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 11'b0_00000001_1_0, 10, 0};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 11'b0_11111111_1_1, 11, 0};

    RST            = 1'b0;
    bus.P_DATA     = 8'hA5;
    bus.PAR_EN     = 1'b1;
    bus.Data_Valid = 1'b1;
    par_typ        = 1'b0;
    #12;
    chk("reset tx", 32'(bus.TX_OUT), 32'd1);
    chk("reset busy", 32'(bus.Busy), 32'd0);
    chk("reset gen_en", 32'(bus.Par_Gen_EN), 32'd0);
    chk("reset par_data", 32'(bus.Par_Data), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    // Data_Valid is already high on the first edge after release.
    check_frame(8'hA5, vecs[0].bits, 11, 0, 8'h00, "post_reset");

    for (int k = 0; k < 7; k++) send(vecs[k], $sformatf("vec%0d", k));

    // Data_Valid held high: 0xFF then 0x00 with exactly one idle cycle between.
    bus.P_DATA     = 8'hFF;
    bus.PAR_EN     = 1'b0;
    bus.Data_Valid = 1'b1;
    check_frame(8'hFF, 11'b0_11111111_1_0, 10, 2, 8'h00, "b2b_first");
    check_frame(8'h00, 11'b0_00000000_1_0, 10, 0, 8'h00, "b2b_second");

    // Reset during DATA bit 3 aborts the frame immediately.
    bus.P_DATA     = 8'hA5;
    bus.PAR_EN     = 1'b1;
    par_typ        = 1'b0;
    bus.Data_Valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    chk("abort bit3 tx", 32'(bus.TX_OUT), 32'd0);
    #1 RST = 1'b0;
    #1;
    chk("abort tx", 32'(bus.TX_OUT), 32'd1);
    chk("abort busy", 32'(bus.Busy), 32'd0);
    chk("abort gen_en", 32'(bus.Par_Gen_EN), 32'd0);
    chk("abort par_data", 32'(bus.Par_Data), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      chk($sformatf("abort quiet tx[%0d]", i), 32'(bus.TX_OUT), 32'd1);
      chk($sformatf("abort quiet busy[%0d]", i), 32'(bus.Busy), 32'd0);
    end
    send(vecs[0], "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
